// File: rtl/md_sequencer_if.sv
// ---------------------------------------------------------------------------
// md_sequencer_if
//
// Bundle between the execute stage and the iterative multiply/divide
// sequencer.
//
// Handshake: the pipeline raises StartE together with OpE/SrcAE/SrcBE/RdE
// while the M-extension instruction sits in E. It keeps all of them stable
// for as long as StallMD is high, because E is frozen. The sequencer accepts
// the operation on the first clock edge where it is idle, StartE=1 and
// FlushE=0. It returns the answer as a one-cycle DoneMD pulse with
// ResultMD/RdMD valid. StallMD is low in that cycle, so the instruction
// leaves E carrying the result. FlushE kills whatever is in flight and never
// produces a DoneMD pulse.
//
// Signals (directions as seen by the sequencer, i.e. the slave modport):
//   StartE    in   E holds a multiply/divide op
//   OpE       in   3-bit M-extension function select
//   SrcAE     in   operand A (rs1)
//   SrcBE     in   operand B (rs2)
//   RdE       in   destination register
//   FlushE    in   kill E / abort the sequencer
//   StallMD   out  stall F/D/E
//   BusyMD    out  iterating
//   DoneMD    out  result valid pulse
//   ResultMD  out  result word
//   RdMD      out  destination register of the result
// ---------------------------------------------------------------------------
interface md_sequencer_if #(
    parameter int XLEN = 32
);
    logic            StartE;
    logic [2:0]      OpE;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic [4:0]      RdE;
    logic            FlushE;
    logic            StallMD;
    logic            BusyMD;
    logic            DoneMD;
    logic [XLEN-1:0] ResultMD;
    logic [4:0]      RdMD;

    // Pipeline side
    modport master (
        output StartE, OpE, SrcAE, SrcBE, RdE, FlushE,
        input  StallMD, BusyMD, DoneMD, ResultMD, RdMD
    );

    // Sequencer side
    modport slave (
        input  StartE, OpE, SrcAE, SrcBE, RdE, FlushE,
        output StallMD, BusyMD, DoneMD, ResultMD, RdMD
    );
endinterface

// File: rtl/md_sequencer.sv
// ---------------------------------------------------------------------------
// md_sequencer
//
// Iterative RV32M multiply/divide unit for the execute stage. It runs a
// radix-2 shift-add multiply or a restoring divide on operand magnitudes,
// one bit per cycle for XLEN cycles. The sign is applied on the final
// iteration. Divide-by-zero and signed overflow skip the iteration and
// answer immediately.
//
// Ports:
//   clk        clock
//   rst        asynchronous reset, active-high
//   bus        md_sequencer_if slave modport (see the interface for signals)
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Latency: accepted on edge N, RUN over edges N+1..N+XLEN, DoneMD during the
// cycle after edge N+XLEN. Special-case divides: DoneMD in the cycle after N.
// ---------------------------------------------------------------------------
module md_sequencer #(
    parameter int XLEN = 32,
    parameter int CW   = 6
) (
    input  logic          clk,
    input  logic          rst,
    md_sequencer_if.slave bus,
    output logic [1:0]    state_dbg
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic              neg_main_q;   // negate product / quotient
    logic              neg_rem_q;    // negate remainder (dividend sign)
    logic [XLEN-1:0]   opnd_q;       // multiplicand or divisor magnitude
    // Shared accumulator:
    //   multiply: {partial_hi, multiplier bits still to consume / product lo}
    //   divide:   {partial remainder, dividend bits shifting into quotient}
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   result_q;
    logic              done_q;
    logic              busy_q;

    // ------------------------------------------------------------------
    // Start decode: signedness, magnitudes and special-case divides
    // ------------------------------------------------------------------
    logic            is_div;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_result;

    always_comb begin
        is_div   = bus.OpE[2];
        // MUL only keeps the low word, so it is run unsigned.
        a_signed = (bus.OpE == OP_MULH) || (bus.OpE == OP_MULHSU) ||
                   (bus.OpE == OP_DIV)  || (bus.OpE == OP_REM);
        b_signed = (bus.OpE == OP_MULH) || (bus.OpE == OP_DIV) ||
                   (bus.OpE == OP_REM);
        a_neg    = a_signed && bus.SrcAE[XLEN-1];
        b_neg    = b_signed && bus.SrcBE[XLEN-1];
        a_mag    = a_neg ? (~bus.SrcAE + 1'b1) : bus.SrcAE;
        b_mag    = b_neg ? (~bus.SrcBE + 1'b1) : bus.SrcBE;

        div_zero = is_div && (bus.SrcBE == '0);
        div_ovf  = is_div && !bus.OpE[0] && (bus.SrcAE == INT_MIN) &&
                   (bus.SrcBE == '1);
        special  = div_zero || div_ovf;

        // OpE[1] distinguishes remainder from quotient. On signed overflow
        // the quotient is the dividend itself (INT_MIN).
        special_result = '0;
        if (div_zero) begin
            special_result = bus.OpE[1] ? bus.SrcAE : '1;
        end else if (div_ovf) begin
            special_result = bus.OpE[1] ? '0 : bus.SrcAE;
        end
    end

    // ------------------------------------------------------------------
    // One iteration of the datapath
    // ------------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] acc_next;

    always_comb begin
        // Shift-add: add the multiplicand into the high half when the
        // current multiplier bit is set. Then shift the whole accumulator
        // right, with the carry entering at the top.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                   {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // Restoring divide: bring the next dividend bit into the partial
        // remainder and trial-subtract. A non-negative difference produces
        // a 1 quotient bit. The remainder stays below the divisor, so
        // XLEN+1 bits are enough to hold the difference.
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (!div_diff[XLEN]) begin
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end

        acc_next = op_q[2] ? div_next : mul_next;
    end

    // ------------------------------------------------------------------
    // Sign fix and result select, applied on the final iteration
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   quo_raw;
    logic [XLEN-1:0]   rem_raw;
    logic [XLEN-1:0]   div_res;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        prod_fixed = neg_main_q ? (~acc_next + 1'b1) : acc_next;
        mul_res    = (op_q[1:0] == 2'b00) ? prod_fixed[XLEN-1:0]
                                          : prod_fixed[2*XLEN-1:XLEN];

        quo_raw = acc_next[XLEN-1:0];
        rem_raw = acc_next[2*XLEN-1:XLEN];
        if (op_q[1]) begin
            div_res = neg_rem_q ? (~rem_raw + 1'b1) : rem_raw;
        end else begin
            div_res = neg_main_q ? (~quo_raw + 1'b1) : quo_raw;
        end

        final_res = op_q[2] ? div_res : mul_res;
    end

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.StartE && !bus.FlushE) begin
                        op_q       <= bus.OpE;
                        rd_q       <= bus.RdE;
                        neg_main_q <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        cnt        <= '0;
                        opnd_q     <= is_div ? b_mag : a_mag;
                        acc_q      <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                        if (special) begin
                            result_q <= special_result;
                            done_q   <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            busy_q <= 1'b1;
                            state  <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    if (bus.FlushE) begin
                        busy_q <= 1'b0;
                        cnt    <= '0;
                        state  <= S_IDLE;
                    end else begin
                        acc_q <= acc_next;
                        cnt   <= cnt + CW'(1);
                        if (cnt == LAST_ITER) begin
                            result_q <= final_res;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            cnt      <= '0;
                            state    <= S_DONE;
                        end
                    end
                end

                // The instruction that owns the result is leaving E now.
                // Any StartE seen here belongs to that instruction, not a
                // new one.
                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The stall is combinational so the hazard unit freezes E in the same
    // cycle the op is offered. It drops in DONE to let the result leave.
    assign bus.StallMD  = !rst &&
                          (((state == S_IDLE) && bus.StartE && !bus.FlushE) ||
                           (state == S_RUN));
    assign bus.BusyMD   = busy_q;
    assign bus.DoneMD   = done_q;
    assign bus.ResultMD = result_q;
    assign bus.RdMD     = rd_q;
    assign state_dbg    = state;

endmodule

// File: tb/tb_md_sequencer.sv
// ---------------------------------------------------------------------------
// tb_md_sequencer
//
// Drives md_sequencer with directed and random M-extension operations.
// Expected {rd, result} pairs come from an arithmetic reference model and
// are queued at issue. A monitor pops them on every DoneMD pulse.
// ---------------------------------------------------------------------------
module tb_md_sequencer;
    localparam int XLEN = 32;
    localparam int EW   = XLEN + 5;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    md_sequencer_if #(.XLEN(XLEN)) bus ();
    logic [1:0] state_dbg;

    md_sequencer #(.XLEN(XLEN), .CW(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [EW-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic is_special(input logic [2:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
        return op[2] && ((b == 32'd0) ||
               (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] op,
                                           input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        int     sai = $signed(a);
        int     sbi = $signed(b);
        logic   ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        longint p;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return a;
                return 32'(sai / sbi);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'd0;
                return 32'(sai % sbi);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        int stalls;
        int lat;
        lat = is_special(op, a, b) ? 1 : 33;
        @(negedge clk);
        bus.StartE = 1'b1;
        bus.OpE    = op;
        bus.SrcAE  = a;
        bus.SrcBE  = b;
        bus.RdE    = rd;
        bus.FlushE = 1'b0;
        exp_q.push_back({rd, ref_md(op, a, b)});
        stalls = 0;
        #1;
        while (bus.StallMD && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        check("stall_cycles", 64'(stalls), 64'(lat));
        check("done_when_stall_drops", {63'd0, bus.DoneMD}, 64'd1);
        bus.StartE = 1'b0;
        bus.SrcAE  = $urandom;
        bus.SrcBE  = $urandom;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic prev_done = 1'b0;
    always begin
        logic [EW-1:0] e;
        @(negedge clk);
        #1;
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (bus.DoneMD) begin
                check("done_single_cycle", {63'd0, prev_done}, 64'd0);
                check("stall_low_in_done", {63'd0, bus.StallMD}, 64'd0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got result %h rd %0d, expected no pulse",
                             bus.ResultMD, bus.RdMD);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 64'(bus.ResultMD), 64'(e[XLEN-1:0]));
                    check("rd", 64'(bus.RdMD), 64'(e[EW-1:XLEN]));
                end
            end
            prev_done = bus.DoneMD;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] held;
        rst        = 1'b0;
        bus.StartE = 1'b0;
        bus.OpE    = 3'd0;
        bus.SrcAE  = '0;
        bus.SrcBE  = '0;
        bus.RdE    = '0;
        bus.FlushE = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_stall",  {63'd0, bus.StallMD}, 64'd0);
        check("reset_busy",   {63'd0, bus.BusyMD},  64'd0);
        check("reset_done",   {63'd0, bus.DoneMD},  64'd0);
        check("reset_result", 64'(bus.ResultMD), 64'd0);
        check("reset_rd",     64'(bus.RdMD), 64'd0);
        check("reset_state",  64'(state_dbg), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);          // MUL 7 * -3
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);  // MULH
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);  // MULHSU
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);  // MULHU
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);          // DIV -7/2
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);          // REM -7/2
        issue(3'd5, 32'd100, 32'd7, 5'd7);                // DIVU
        issue(3'd7, 32'd100, 32'd7, 5'd8);                // REMU
        issue(3'd5, 32'd5, 32'd0, 5'd10);                 // DIVU by zero
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11); // REM overflow
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12); // DIV overflow
        issue(3'd6, 32'd77, 32'd0, 5'd13);                // REM by zero

        // StartE and FlushE together in IDLE: no start
        @(negedge clk);
        held       = bus.ResultMD;
        bus.StartE = 1'b1;
        bus.OpE    = 3'd0;
        bus.SrcAE  = 32'd9;
        bus.SrcBE  = 32'd9;
        bus.FlushE = 1'b1;
        #1;
        check("flush_start_stall", {63'd0, bus.StallMD}, 64'd0);
        @(negedge clk);
        bus.StartE = 1'b0;
        bus.FlushE = 1'b0;
        #1;
        check("flush_start_busy", {63'd0, bus.BusyMD}, 64'd0);

        // Flush mid-divide
        @(negedge clk);
        bus.StartE = 1'b1;
        bus.OpE    = 3'd4;
        bus.SrcAE  = 32'd1000;
        bus.SrcBE  = 32'd7;
        bus.RdE    = 5'd9;
        repeat (11) @(negedge clk);
        #1;
        check("busy_before_flush", {63'd0, bus.BusyMD}, 64'd1);
        bus.FlushE = 1'b1;
        @(negedge clk);
        bus.StartE = 1'b0;
        bus.FlushE = 1'b0;
        #1;
        check("flush_stall_low", {63'd0, bus.StallMD}, 64'd0);
        check("flush_busy_low",  {63'd0, bus.BusyMD},  64'd0);
        check("flush_result_kept", 64'(bus.ResultMD), 64'(held));
        repeat (40) @(negedge clk);
        issue(3'd0, 32'd3, 32'd4, 5'd14);                 // MUL 3*4

        // Reset mid-run
        @(negedge clk);
        bus.StartE = 1'b1;
        bus.OpE    = 3'd0;
        bus.SrcAE  = 32'd11;
        bus.SrcBE  = 32'd13;
        bus.RdE    = 5'd21;
        repeat (10) @(negedge clk);
        #1;
        check("busy_before_reset", {63'd0, bus.BusyMD}, 64'd1);
        #1 rst = 1'b1;
        #1;
        check("midrun_reset_stall",  {63'd0, bus.StallMD}, 64'd0);
        check("midrun_reset_busy",   {63'd0, bus.BusyMD},  64'd0);
        check("midrun_reset_done",   {63'd0, bus.DoneMD},  64'd0);
        check("midrun_reset_result", 64'(bus.ResultMD), 64'd0);
        check("midrun_reset_rd",     64'(bus.RdMD), 64'd0);
        @(negedge clk);
        bus.StartE = 1'b0;
        rst        = 1'b0;
        issue(3'd5, 32'd9, 32'd3, 5'd15);                 // DIVU 9/3

        // Random operations
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                  5'($urandom_range(0, 31)));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
